frequency_counter_multichannel: RTL and testbench

Measures the frequency of NUMBER_OF_CHANNELS independent unknown clocks against one reference clock over a common gate window.
Each unknown clock drives a free-running Gray-coded edge counter. The counts are synchronised into reference_clock and differenced across each gate. Each delta is scaled to Hz and saturated, then stored in a per-channel result bank.
Used on board-monitor / UART status paths wherever several recovered or external clocks must be reported at once, including detection of stopped clocks.

---
 rtl/frequency_counter_multichannel_pkg.sv | 26 ++
 rtl/frequency_counter_multichannel_if.sv | 14 +
 rtl/frequency_counter_edge_counter.sv | 32 +++
 rtl/frequency_counter_multichannel.sv | 210 +++++++++++++++++++++
 tb/tb_frequency_counter_multichannel.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/frequency_counter_multichannel_pkg.sv
// Shared types and helpers for the multichannel frequency counter.
// Gray helpers work on 32-bit words; callers zero-extend narrower counts.
package frequency_counter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [31:0] SATURATED_VALUE = 32'hFFFF_FFFF;

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i + 1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/frequency_counter_multichannel_if.sv
// Readout bus of the frequency counter: channel index in, selected result and status out.
interface frequency_counter_multichannel_if #(
    parameter int CHANNEL_SELECT_WIDTH = 2
);
    logic [CHANNEL_SELECT_WIDTH-1:0] channel_select;
    logic [31:0]                     frequency;
    logic                            overflow;
    logic                            stalled;
    logic                            valid;
    logic [15:0]                     gate_count;

    modport master (output channel_select, input frequency, overflow, stalled, valid, gate_count);
    modport slave  (input channel_select, output frequency, overflow, stalled, valid, gate_count);
endinterface

// File: rtl/frequency_counter_edge_counter.sv
// Free-running Gray edge counter in the unknown clock domain, synchronised into
// reference_clock and returned as a binary count. COUNTER_WIDTH must not exceed 32.
module frequency_counter_edge_counter
    import frequency_counter_pkg::*;
#(
    parameter int COUNTER_WIDTH = 24
) (
    input  logic                     unknown_clock,
    input  logic                     reference_clock,
    output logic [COUNTER_WIDTH-1:0] count
);

    logic [COUNTER_WIDTH-1:0] binary_r;
    logic [COUNTER_WIDTH-1:0] gray_r;
    logic [COUNTER_WIDTH-1:0] sync_meta_r;
    logic [COUNTER_WIDTH-1:0] sync_r;

    // Only gray_r crosses domains, so at most one bit is in flight per sample
    always_ff @(posedge unknown_clock) begin
        binary_r <= binary_r + COUNTER_WIDTH'(1'b1);
        gray_r   <= COUNTER_WIDTH'(bin2gray(32'(binary_r)));
    end

    // Two-stage synchroniser into the reference domain
    always_ff @(posedge reference_clock) begin
        sync_meta_r <= gray_r;
        sync_r      <= sync_meta_r;
    end

    assign count = COUNTER_WIDTH'(gray2bin(32'(sync_r)));

endmodule

// File: rtl/frequency_counter_multichannel.sv
// Multichannel frequency counter: common gate, per-channel delta scaled to Hz into a bank.
// Optional exponential averaging of stored results: FREQUENCY_COUNTER_MULTICHANNEL_AVERAGING_EN.
module frequency_counter_multichannel
    import frequency_counter_pkg::*;
#(
    parameter int NUMBER_OF_CHANNELS           = 4,
    parameter int FREQUENCY_OF_REFERENCE_CLOCK = 25000000,
    parameter int RATE_HZ                      = 1000,
    parameter int GATE_CYCLES                  = FREQUENCY_OF_REFERENCE_CLOCK / RATE_HZ,
    parameter int COUNTER_WIDTH                = 24,
    parameter int CHANNEL_SELECT_WIDTH         = (NUMBER_OF_CHANNELS > 1) ? $clog2(NUMBER_OF_CHANNELS) : 1
) (
    input  logic                          reference_clock,
    input  logic                          reset,
    input  logic [NUMBER_OF_CHANNELS-1:0] unknown_clock,
    frequency_counter_multichannel_if.slave bus
);

    localparam int TIMER_WIDTH   = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int PRODUCT_WIDTH = COUNTER_WIDTH + 32;

    logic [COUNTER_WIDTH-1:0]        count_s          [NUMBER_OF_CHANNELS];
    logic [COUNTER_WIDTH-1:0]        snapshot_r       [NUMBER_OF_CHANNELS];
    logic [COUNTER_WIDTH-1:0]        previous_r       [NUMBER_OF_CHANNELS];
    logic [31:0]                     bank_frequency_r [NUMBER_OF_CHANNELS];
    logic                            bank_overflow_r  [NUMBER_OF_CHANNELS];
    logic                            bank_stalled_r   [NUMBER_OF_CHANNELS];
    logic [TIMER_WIDTH-1:0]          timer_r;
    logic                            gate_end_s;
    state_t                          state_r, state_next_s;
    logic [CHANNEL_SELECT_WIDTH-1:0] index_r, index_next_s, select_s;
    logic                            last_channel_s, primed_r, valid_r;
    logic [15:0]                     gate_count_r;
    logic [COUNTER_WIDTH-1:0]        delta_s;
    logic [PRODUCT_WIDTH-1:0]        product_s;
    logic                            saturate_s, stall_s;
    logic [31:0]                     sample_s, result_s;
    logic [31:0]                     read_frequency_s, frequency_r;
    logic                            read_overflow_s, read_stalled_s, overflow_r, stalled_r;

    for (genvar g = 0; g < NUMBER_OF_CHANNELS; g++) begin : g_channel
        frequency_counter_edge_counter #(.COUNTER_WIDTH(COUNTER_WIDTH)) u_edge_counter (
            .unknown_clock   (unknown_clock[g]),
            .reference_clock (reference_clock),
            .count           (count_s[g])
        );
    end

    assign gate_end_s     = (timer_r == TIMER_WIDTH'(GATE_CYCLES - 1));
    assign last_channel_s = (index_r == CHANNEL_SELECT_WIDTH'(NUMBER_OF_CHANNELS - 1));
    assign select_s       = bus.channel_select;

    // Gate timer keeps running through COMPUTE so gates stay equally spaced
    always_ff @(posedge reference_clock) begin
        if (reset) begin
            timer_r <= TIMER_WIDTH'(1'b0);
        end else if (gate_end_s) begin
            timer_r <= TIMER_WIDTH'(1'b0);
        end else begin
            timer_r <= timer_r + TIMER_WIDTH'(1'b1);
        end
    end

    // Next-state logic: walk the channels one per cycle after each gate
    always_comb begin
        state_next_s = state_r;
        index_next_s = index_r;
        case (state_r)
            IDLE: begin
                if (gate_end_s) begin
                    state_next_s = COMPUTE;
                    index_next_s = CHANNEL_SELECT_WIDTH'(1'b0);
                end else begin
                    state_next_s = IDLE;
                end
            end
            COMPUTE: begin
                if (last_channel_s) begin
                    state_next_s = DONE;
                end else begin
                    index_next_s = index_r + CHANNEL_SELECT_WIDTH'(1'b1);
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register, priming, valid pulse and update counter
    always_ff @(posedge reference_clock) begin
        if (reset) begin
            state_r      <= IDLE;
            index_r      <= CHANNEL_SELECT_WIDTH'(1'b0);
            primed_r     <= 1'b0;
            valid_r      <= 1'b0;
            gate_count_r <= 16'd0;
        end else begin
            state_r  <= state_next_s;
            index_r  <= index_next_s;
            valid_r  <= (state_next_s == DONE) && primed_r;
            if ((state_next_s == DONE) && primed_r) begin
                gate_count_r <= gate_count_r + 16'd1;
            end
            if ((state_r == COMPUTE) && last_channel_s) begin
                primed_r <= 1'b1;
            end
        end
    end

    // Gate snapshot and previous counts need no reset: the priming gate reloads them
    always_ff @(posedge reference_clock) begin
        if (gate_end_s) begin
            for (int i = 0; i < NUMBER_OF_CHANNELS; i++) begin
                snapshot_r[i] <= count_s[i];
            end
        end
        if (state_r == COMPUTE) begin
            previous_r[index_r] <= snapshot_r[index_r];
        end
    end

    // Delta is modular, so counter wrap-around drops out of the subtraction
    always_comb begin
        delta_s    = snapshot_r[index_r] - previous_r[index_r];
        product_s  = PRODUCT_WIDTH'(delta_s) * PRODUCT_WIDTH'(RATE_HZ);
        saturate_s = |product_s[PRODUCT_WIDTH-1:32];
        sample_s   = saturate_s ? SATURATED_VALUE : product_s[31:0];
        stall_s    = (delta_s == COUNTER_WIDTH'(1'b0));
    end

`ifdef FREQUENCY_COUNTER_MULTICHANNEL_AVERAGING_EN
    logic        has_result_r;
    logic [33:0] blend_s;

    // The first bank update after reset seeds the average
    always_ff @(posedge reference_clock) begin
        if (reset) begin
            has_result_r <= 1'b0;
        end else if (valid_r) begin
            has_result_r <= 1'b1;
        end else begin
            has_result_r <= has_result_r;
        end
    end

    assign blend_s = ({2'b00, bank_frequency_r[index_r]} * 34'd3) + {2'b00, sample_s};

    // Stalled and saturated samples bypass the filter so they show at once
    always_comb begin
        if (stall_s) begin
            result_s = 32'd0;
        end else if (saturate_s) begin
            result_s = SATURATED_VALUE;
        end else if (!has_result_r) begin
            result_s = sample_s;
        end else begin
            result_s = blend_s[33:2];
        end
    end
`else
    assign result_s = sample_s;
`endif

    // Result bank: one channel written per COMPUTE cycle once primed
    always_ff @(posedge reference_clock) begin
        if (reset) begin
            for (int i = 0; i < NUMBER_OF_CHANNELS; i++) begin
                bank_frequency_r[i] <= 32'd0;
                bank_overflow_r[i]  <= 1'b0;
                bank_stalled_r[i]   <= 1'b0;
            end
        end else if ((state_r == COMPUTE) && primed_r) begin
            bank_frequency_r[index_r] <= result_s;
            bank_overflow_r[index_r]  <= saturate_s;
            bank_stalled_r[index_r]   <= stall_s;
        end
    end

    // Readout mux; an index with no channel behind it reads as zero
    always_comb begin
        read_frequency_s = 32'd0;
        read_overflow_s  = 1'b0;
        read_stalled_s   = 1'b0;
        for (int i = 0; i < NUMBER_OF_CHANNELS; i++) begin
            read_frequency_s = (select_s == CHANNEL_SELECT_WIDTH'(i)) ? bank_frequency_r[i] : read_frequency_s;
            read_overflow_s  = (select_s == CHANNEL_SELECT_WIDTH'(i)) ? bank_overflow_r[i]  : read_overflow_s;
            read_stalled_s   = (select_s == CHANNEL_SELECT_WIDTH'(i)) ? bank_stalled_r[i]   : read_stalled_s;
        end
    end

    // Registered readout
    always_ff @(posedge reference_clock) begin
        if (reset) begin
            frequency_r <= 32'd0;
            overflow_r  <= 1'b0;
            stalled_r   <= 1'b0;
        end else begin
            frequency_r <= read_frequency_s;
            overflow_r  <= read_overflow_s;
            stalled_r   <= read_stalled_s;
        end
    end

    assign bus.frequency  = frequency_r;
    assign bus.overflow   = overflow_r;
    assign bus.stalled    = stalled_r;
    assign bus.valid      = valid_r;
    assign bus.gate_count = gate_count_r;

endmodule

// File: tb/tb_frequency_counter_multichannel.sv
// Bench for frequency_counter_multichannel: a 4-channel instance (short gate) and a
// 3-channel 8-bit-counter instance with a high rate for saturation, wrap and stall.
`timescale 1ns/1ps
module tb_frequency_counter_multichannel;

    localparam int  GATE   = 250;
    localparam int  N_A    = 4;
    localparam int  N_B    = 3;
    localparam int  RATE_A = 100000;
    localparam int  RATE_B = 20000000;

    typedef struct {
        bit         dut_b;
        logic [1:0] sel;
        longint     freq;
        longint     tol;
        logic       ovf;
        logic       stl;
    } rd_t;

    logic reference_clock = 1'b0;
    logic reset = 1'b1;
    logic run2 = 1'b1;
    logic c0 = 1'b0, c1 = 1'b0, c2 = 1'b0, c3 = 1'b0, b0 = 1'b0, b1 = 1'b0;
    logic [N_A-1:0] uclk_a;
    logic [N_B-1:0] uclk_b;
    int   cycle_count = 0;
    int   compared = 0;
    int   mismatched = 0;
    rd_t  sb_q[$];
    rd_t  tbl_a [5];
    rd_t  tbl_b [4];

    assign uclk_a = {c3, c2, c1, c0};
    assign uclk_b = {1'b0, b1, b0};

    frequency_counter_multichannel_if #(.CHANNEL_SELECT_WIDTH(2)) bus_a ();
    frequency_counter_multichannel_if #(.CHANNEL_SELECT_WIDTH(2)) bus_b ();

    frequency_counter_multichannel #(
        .NUMBER_OF_CHANNELS(N_A), .FREQUENCY_OF_REFERENCE_CLOCK(25000000), .RATE_HZ(RATE_A),
        .GATE_CYCLES(GATE), .COUNTER_WIDTH(24), .CHANNEL_SELECT_WIDTH(2)
    ) dut_a (
        .reference_clock(reference_clock), .reset(reset), .unknown_clock(uclk_a), .bus(bus_a)
    );

    frequency_counter_multichannel #(
        .NUMBER_OF_CHANNELS(N_B), .FREQUENCY_OF_REFERENCE_CLOCK(25000000), .RATE_HZ(RATE_B),
        .GATE_CYCLES(GATE), .COUNTER_WIDTH(8), .CHANNEL_SELECT_WIDTH(2)
    ) dut_b (
        .reference_clock(reference_clock), .reset(reset), .unknown_clock(uclk_b), .bus(bus_b)
    );

    always #20 reference_clock = ~reference_clock;
    always @(posedge reference_clock) cycle_count <= cycle_count + 1;

    initial begin #3;  forever #50     c0 = ~c0; end
    initial begin #7;  forever #450    c1 = ~c1; end
    initial begin #5;  forever #1500   c2 = run2 ? ~c2 : 1'b0; end
    initial begin #2;  forever #11.25  c3 = ~c3; end
    initial begin #4;  forever #25     b0 = ~b0; end
    initial begin #6;  forever #20.833 b1 = ~b1; end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic rd_t mk(input bit dut_b, input logic [1:0] sel, input longint freq,
                               input longint tol, input logic ovf, input logic stl);
        rd_t r;
        r.dut_b = dut_b; r.sel = sel; r.freq = freq; r.tol = tol; r.ovf = ovf; r.stl = stl;
        return r;
    endfunction

    task automatic check(input string name, input longint got, input longint exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_near(input string name, input longint got, input longint exp, input longint tol);
        compared++;
        if ((got > exp + tol) || (got < exp - tol)) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", name, got, exp, tol);
        end
    endtask

    task automatic compare_front();
        rd_t    e;
        longint f;
        logic   o, s;
        string  tag;
        e   = sb_q.pop_front();
        f   = e.dut_b ? longint'({32'd0, bus_b.frequency}) : longint'({32'd0, bus_a.frequency});
        o   = e.dut_b ? bus_b.overflow : bus_a.overflow;
        s   = e.dut_b ? bus_b.stalled  : bus_a.stalled;
        tag = $sformatf("%s ch%0d", e.dut_b ? "dut_b" : "dut_a", e.sel);
        check_near({tag, " frequency"}, f, e.freq, e.tol);
        check({tag, " overflow"}, longint'(o), longint'(e.ovf));
        check({tag, " stalled"},  longint'(s), longint'(e.stl));
    endtask

    task automatic readout(input rd_t v);
        if (v.dut_b) bus_b.channel_select = v.sel;
        else         bus_a.channel_select = v.sel;
        sb_q.push_back(v);
        @(posedge reference_clock);
        @(negedge reference_clock);
        compare_front();
    endtask

    task automatic wait_valid(output int t);
        int n = 0;
        do begin
            @(negedge reference_clock);
            n++;
        end while (!bus_a.valid && (n < 2000));
        t = cycle_count;
    endtask

    initial begin
        int t0, t1, t2, t;

        tbl_a[0] = mk(1'b0, 2'd0, 64'd10000000, RATE_A, 1'b0, 1'b0);
        tbl_a[1] = mk(1'b0, 2'd1, 64'd1111111,  RATE_A, 1'b0, 1'b0);
        tbl_a[2] = mk(1'b0, 2'd2, 64'd333333,   RATE_A, 1'b0, 1'b0);
        tbl_a[3] = mk(1'b0, 2'd3, 64'd44444444, RATE_A, 1'b0, 1'b0);
        tbl_a[4] = mk(1'b0, 2'd0, 64'd10000000, RATE_A, 1'b0, 1'b0);
        tbl_b[0] = mk(1'b1, 2'd0, 64'd4000000000, RATE_B, 1'b0, 1'b0);
        tbl_b[1] = mk(1'b1, 2'd1, 64'd4294967295, 64'd0, 1'b1, 1'b0);
        tbl_b[2] = mk(1'b1, 2'd2, 64'd0,          64'd0, 1'b0, 1'b1);
        tbl_b[3] = mk(1'b1, 2'd3, 64'd0,          64'd0, 1'b0, 1'b0);

        bus_a.channel_select = 2'd0;
        bus_b.channel_select = 2'd0;
        reset = 1'b1;
        repeat (3) @(posedge reference_clock);
        @(negedge reference_clock);
        check("reset frequency",  longint'(bus_a.frequency),  64'd0);
        check("reset overflow",   longint'(bus_a.overflow),   64'd0);
        check("reset stalled",    longint'(bus_a.stalled),    64'd0);
        check("reset valid",      longint'(bus_a.valid),      64'd0);
        check("reset gate_count", longint'(bus_a.gate_count), 64'd0);
        check("reset valid b",    longint'(bus_b.valid),      64'd0);

        // Priming gate gives no valid; first valid N+1 cycles after the second gate end
        reset = 1'b0;
        t0 = cycle_count;
        wait_valid(t1);
        check("first valid latency", longint'(t1 - t0), longint'(2 * GATE + N_A));
        check("gate_count first", longint'(bus_a.gate_count), 64'd1);
        @(negedge reference_clock);
        check("valid width", longint'(bus_a.valid), 64'd0);

        for (int i = 0; i < 5; i++) readout(tbl_a[i]);
        for (int i = 0; i < 4; i++) readout(tbl_b[i]);

        wait_valid(t2);
        check("valid period", longint'(t2 - t1), longint'(GATE));
        check("gate_count second", longint'(bus_a.gate_count), 64'd2);

        // Stop channel 2; the gate after the partial one must read stalled
        run2 = 1'b0;
        wait_valid(t);
        wait_valid(t);
        check("gate_count fourth", longint'(bus_a.gate_count), 64'd4);
        readout(mk(1'b0, 2'd2, 64'd0, 64'd0, 1'b0, 1'b1));
        readout(mk(1'b0, 2'd0, 64'd10000000, RATE_A, 1'b0, 1'b0));
        readout(mk(1'b0, 2'd3, 64'd44444444, RATE_A, 1'b0, 1'b0));

        // 8-bit counters wrap every gate or so; results must stay steady
        for (int g = 0; g < 5; g++) begin
            wait_valid(t);
            readout(tbl_b[0]);
            readout(tbl_b[1]);
        end

        // Reset in the middle of COMPUTE
        bus_a.channel_select = 2'd0;
        wait_valid(t);
        repeat (GATE - N_A + 1) @(posedge reference_clock);
        @(negedge reference_clock);
        reset = 1'b1;
        @(posedge reference_clock);
        @(negedge reference_clock);
        check("abort frequency",  longint'(bus_a.frequency),  64'd0);
        check("abort valid",      longint'(bus_a.valid),      64'd0);
        check("abort gate_count", longint'(bus_a.gate_count), 64'd0);
        check("abort overflow b", longint'(bus_b.overflow),   64'd0);
        reset = 1'b0;
        t0 = cycle_count;
        wait_valid(t1);
        check("valid after abort", longint'(t1 - t0), longint'(2 * GATE + N_A));
        check("gate_count restart", longint'(bus_a.gate_count), 64'd1);
        readout(mk(1'b0, 2'd1, 64'd1111111, RATE_A, 1'b0, 1'b0));
        readout(mk(1'b0, 2'd2, 64'd0, 64'd0, 1'b0, 1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
